// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath blocks.
// mmm_state_t : Montgomery multiplier sequencing states.
// MMM_ACC_EXTRA : guard bits carried by the Montgomery accumulator above WIDTH.
package rsa_pkg;

  typedef enum logic [1:0] {
    MMM_IDLE,
    MMM_RUN,
    MMM_REDUCE,
    MMM_DONE
  } mmm_state_t;

  localparam int unsigned MMM_ACC_EXTRA = 2;

endpackage

// File: rtl/mmm_step.sv
// One combinational radix-2 Montgomery iteration: acc_o = (acc + a*B [+ M]) / 2,
// with M added only when needed to make the sum even.
// Ports:
//   acc_i   - current accumulator (WIDTH+2 bits)
//   a_bit_i - current multiplier bit
//   b_i     - multiplicand B
//   m_i     - odd modulus M
//   acc_o   - next accumulator (WIDTH+2 bits)
module mmm_step
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH+MMM_ACC_EXTRA-1:0] acc_i,
  input  logic                           a_bit_i,
  input  logic [WIDTH-1:0]               b_i,
  input  logic [WIDTH-1:0]               m_i,
  output logic [WIDTH+MMM_ACC_EXTRA-1:0] acc_o
);

  localparam int unsigned AccW = WIDTH + MMM_ACC_EXTRA;

  logic [AccW-1:0] t_add;
  logic [AccW-1:0] t_red;

  // acc < 2M and B, M < 2^WIDTH keep acc + B + M below 4M, so AccW never overflows.
  always_comb begin
    t_add = acc_i + (a_bit_i ? AccW'(b_i) : '0);
    t_red = t_add[0] ? (t_add + AccW'(m_i)) : t_add;
    acc_o = t_red >> 1;
  end

endmodule

// File: rtl/mmm_radix2.sv
// Radix-2 bit-serial Montgomery multiplier: p = A*B*2^-WIDTH mod M.
// A one-cycle ld_a latches the operands; one bit of A is consumed per enabled clock.
// Build option MMM_FINAL_SUB_EN: when defined, a REDUCE cycle performs the final
// conditional subtraction (p < M, latency WIDTH+1); when undefined, p is taken straight
// from the accumulator (p < 2M, latency WIDTH, caller keeps M < 2^(WIDTH-1)).
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   ena   - clock enable, all state holds when 0
//   clear - active-low synchronous abort to IDLE (p keeps its value)
//   ld_a  - load/start pulse, honoured in IDLE or DONE only
//   a_in  - multiplier A (A < M)
//   b_in  - multiplicand B (B < M)
//   m_in  - odd modulus M
//   p     - result register
//   valid - high while p holds a completed result
module mmm_radix2
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clear,
  input  logic             ld_a,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] m_in,
  output logic [WIDTH-1:0] p,
  output logic             valid
);

  localparam int unsigned AccW = WIDTH + MMM_ACC_EXTRA;
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  mmm_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic            valid_q, valid_d;

  logic [AccW-1:0] acc_next;

  mmm_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i   (acc_q),
    .a_bit_i (a_q[0]),
    .b_i     (b_q),
    .m_i     (m_q),
    .acc_o   (acc_next)
  );

`ifdef MMM_FINAL_SUB_EN
  // acc < 2M, so acc - M fits in WIDTH bits and only the low bits are needed.
  logic [WIDTH-1:0] acc_sub;
  logic             acc_ge_m;
  assign acc_sub  = acc_q[WIDTH-1:0] - m_q;
  assign acc_ge_m = (acc_q >= AccW'(m_q));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    acc_d   = acc_q;
    p_d     = p_q;
    valid_d = valid_q;

    if (!clear) begin
      state_d = MMM_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        MMM_IDLE, MMM_DONE: begin
          if (ld_a) begin
            a_d     = a_in;
            b_d     = b_in;
            m_d     = m_in;
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = MMM_RUN;
          end
        end
        MMM_RUN: begin
          acc_d = acc_next;
          a_d   = {1'b0, a_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
`ifdef MMM_FINAL_SUB_EN
            state_d = MMM_REDUCE;
`else
            p_d     = acc_next[WIDTH-1:0];
            valid_d = 1'b1;
            state_d = MMM_DONE;
`endif
          end
        end
`ifdef MMM_FINAL_SUB_EN
        MMM_REDUCE: begin
          p_d     = acc_ge_m ? acc_sub : acc_q[WIDTH-1:0];
          valid_d = 1'b1;
          state_d = MMM_DONE;
        end
`endif
        default: state_d = MMM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MMM_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      valid_q <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      valid_q <= valid_d;
    end
  end

  assign p     = p_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mmm_radix2.sv
module tb_mmm_radix2;

  localparam int unsigned W = 8;
`ifdef MMM_FINAL_SUB_EN
  localparam int LAT = W + 1;
  localparam int MMAX = 255;
`else
  localparam int LAT = W;
  localparam int MMAX = 127;
`endif

  logic         clk = 1'b0;
  logic         rst, ena, clear, ld_a;
  logic [W-1:0] a_in, b_in, m_in;
  logic [W-1:0] p;
  logic         valid;

  int total = 0;
  int bad   = 0;

  mmm_radix2 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .clear (clear),
    .ld_a  (ld_a),
    .a_in  (a_in),
    .b_in  (b_in),
    .m_in  (m_in),
    .p     (p),
    .valid (valid)
  );

  always #5 clk = ~clk;

  // Closed-form Montgomery product: (A*B + q*M) / R with q = -A*B*M^-1 mod R,
  // optionally followed by the final conditional subtraction.
  function automatic logic [W-1:0] mont_ref(input int unsigned a, input int unsigned b,
                                            input int unsigned m);
    longint unsigned r, minv, q, acc;
    r = 64'd1 << W;
    minv = 0;
    for (longint unsigned x = 1; x < r; x += 2)
      if (((m * x) % r) == 1) minv = x;
    q   = (r - ((a * b * minv) % r)) % r;
    acc = (longint'(a) * b + q * m) / r;
`ifdef MMM_FINAL_SUB_EN
    if (acc >= m) acc = acc - m;
`endif
    return acc[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    a_in = a; b_in = b; m_in = m;
    ld_a = 1'b1;
    tick();
    ld_a = 1'b0;
  endtask

  // Load, scramble the operand inputs while running, then check latency and result.
  task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] m);
    logic [W-1:0] exp;
    int n;
    exp = mont_ref(a, b, m);
    load(a, b, m);
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL %s valid_after_load: got %b expected 0", name, valid);
    end
    n = 0;
    while (valid !== 1'b1 && n < 4 * LAT) begin
      a_in = W'($urandom); b_in = W'($urandom); m_in = W'($urandom);
      tick();
      n++;
    end
    total++;
    if (n != LAT) begin
      bad++;
      $display("FAIL %s latency: got %0d expected %0d", name, n, LAT);
    end
    total++;
    if (p !== exp) begin
      bad++;
      $display("FAIL %s result: got %0d expected %0d", name, p, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; clear = 1'b1; ld_a = 1'b0;
    a_in = '0; b_in = '0; m_in = '0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if (p !== '0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL reset: got p=%0d valid=%b expected p=0 valid=0", p, valid);
    end
    repeat (W + 3) tick();
    total++;
    if (valid !== 1'b0 || p !== '0) begin
      bad++;
      $display("FAIL idle_hold: got p=%0d valid=%b expected p=0 valid=0", p, valid);
    end
  endtask

  task automatic test_vectors();
    run_check("v_5x7", 8'd5, 8'd7, 8'd13);
    run_check("v_12x12", 8'd12, 8'd12, 8'd13);
`ifdef MMM_FINAL_SUB_EN
    run_check("v_254x254", 8'd254, 8'd254, 8'd255);
`else
    run_check("v_100x90", 8'd100, 8'd90, 8'd127);
`endif
  endtask

  // Second load lands in the first DONE cycle (run_check returns right there).
  task automatic test_back_to_back();
    run_check("b2b_first", 8'd12, 8'd12, 8'd13);
    run_check("b2b_second", 8'd0, 8'd9, 8'd13);
  endtask

  task automatic test_ena_toggle();
    logic [W-1:0] exp, prev_p;
    logic prev_v;
    int enabled, guard;
    exp = mont_ref(5, 7, 13);
    load(8'd5, 8'd7, 8'd13);
    enabled = 0; guard = 0;
    while (enabled < LAT && guard < 8 * LAT) begin
      ena = guard[0];
      prev_p = p; prev_v = valid;
      tick();
      guard++;
      if (!ena) begin
        total++;
        if (p !== prev_p || valid !== prev_v) begin
          bad++;
          $display("FAIL ena_hold: got p=%0d valid=%b expected p=%0d valid=%b",
                   p, valid, prev_p, prev_v);
        end
      end else begin
        enabled++;
        if (enabled < LAT && valid !== 1'b0) begin
          total++;
          bad++;
          $display("FAIL ena_early_valid: got 1 expected 0 at enabled edge %0d", enabled);
        end
      end
    end
    ena = 1'b1;
    total++;
    if (valid !== 1'b1 || p !== exp) begin
      bad++;
      $display("FAIL ena_result: got p=%0d valid=%b expected p=%0d valid=1", p, valid, exp);
    end
  endtask

  task automatic test_clear();
    logic [W-1:0] p0;
    run_check("clr_pre", 8'd3, 8'd4, 8'd13);
    p0 = mont_ref(3, 4, 13);
    load(8'd5, 8'd7, 8'd13);
    repeat (3) tick();
    clear = 1'b0;
    tick();
    clear = 1'b1;
    total++;
    if (valid !== 1'b0 || p !== p0) begin
      bad++;
      $display("FAIL clear_run: got p=%0d valid=%b expected p=%0d valid=0", p, valid, p0);
    end
    repeat (W + 4) tick();
    total++;
    if (valid !== 1'b0 || p !== p0) begin
      bad++;
      $display("FAIL clear_idle: got p=%0d valid=%b expected p=%0d valid=0", p, valid, p0);
    end
    run_check("clr_after", 8'd5, 8'd7, 8'd13);
    clear = 1'b0;
    tick();
    clear = 1'b1;
    total++;
    if (valid !== 1'b0 || p !== mont_ref(5, 7, 13)) begin
      bad++;
      $display("FAIL clear_done: got p=%0d valid=%b expected p=%0d valid=0",
               p, valid, mont_ref(5, 7, 13));
    end
  endtask

  task automatic test_ld_ignored();
    logic [W-1:0] exp;
    int n;
    exp = mont_ref(5, 7, 13);
    load(8'd5, 8'd7, 8'd13);
    tick(); tick();
    load(8'd9, 8'd11, 8'd15);
    n = 3;
    while (valid !== 1'b1 && n < 4 * LAT) begin
      tick();
      n++;
    end
    total++;
    if (n != LAT || p !== exp) begin
      bad++;
      $display("FAIL ld_ignored: got p=%0d after %0d edges expected p=%0d after %0d",
               p, n, exp, LAT);
    end
  endtask

  task automatic test_rst_run();
    load(8'd12, 8'd12, 8'd13);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (p !== '0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_run: got p=%0d valid=%b expected p=0 valid=0", p, valid);
    end
    run_check("rst_recover", 8'd5, 8'd7, 8'd13);
  endtask

  task automatic test_random();
    int unsigned m, a, b;
    for (int i = 0; i < 24; i++) begin
      m = $urandom_range(MMAX, 3) | 1;
      a = $urandom % m;
      b = $urandom % m;
      run_check($sformatf("rnd%0d", i), W'(a), W'(b), W'(m));
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_ena_toggle();
    test_clear();
    test_ld_ignored();
    test_rst_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
